// File: rtl/sipo_pkg.sv
// Shared types and sizing for the serial-to-parallel receiver.
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   localparam int SIPO_WIDTH = 4;
   localparam int SIPO_CNT_W = $clog2(SIPO_WIDTH + 1);

   // One extra count value so the counter can also mark "data complete, parity pending".
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// Output holding register with valid/ready handshake and sticky overrun.
// SIPO_PARITY_EN adds a parity-error bit held alongside the word.
module sipo_out_buffer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
`ifdef SIPO_PARITY_EN
   input  logic             perr_in,
   output logic             parity_err,
`endif
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
   logic             perr_q, perr_d;
`endif

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
`ifdef SIPO_PARITY_EN
      perr_d    = perr_q;
`endif
      if (valid_q && out_ready) valid_d = 1'b0;
      // An accept on the completing edge frees the register, so the new word loads.
      if (load) begin
         if (valid_q && !out_ready) begin
            overrun_d = 1'b1;
         end else begin
            data_d  = word;
            valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
            perr_d  = perr_in;
`endif
         end
      end
      if (clear) overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   assign parallel_out = data_q;
   assign out_valid    = valid_q;
   assign overrun      = overrun_q;
`ifdef SIPO_PARITY_EN
   assign parity_err   = perr_q;
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver assembling WIDTH-bit words from a qualified bit stream.
// SIPO_PARITY_EN appends an even-parity bit per word and exposes parity_err.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = SIPO_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             serial_in,
   input  logic             serial_valid,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SIPO_PARITY_EN
   output logic             parity_err,
`endif
   output logic             overrun
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             load;
`ifdef SIPO_PARITY_EN
   logic             perr_word;
`endif

   assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], serial_in}
                              : {serial_in, shift_q[WIDTH-1:1]};

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      load    = 1'b0;
      word    = shifted;
`ifdef SIPO_PARITY_EN
      perr_word = 1'b0;
`endif
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end else if (serial_valid) begin
         unique case (state_q)
            IDLE: begin
               shift_d = shifted;
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
            SHIFT: begin
               if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                  shift_d = shifted;
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = PARITY;
`else
                  load    = 1'b1;
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
`endif
               end else begin
                  shift_d = shifted;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
               load      = 1'b1;
               word      = shift_q;
               perr_word = (^shift_q) ^ serial_in;
               shift_d   = '0;
               cnt_d     = '0;
               state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   sipo_out_buffer #(
      .WIDTH(WIDTH)
   ) u_out_buffer (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .load         (load),
      .word         (word),
`ifdef SIPO_PARITY_EN
      .perr_in      (perr_word),
      .parity_err   (parity_err),
`endif
      .out_ready    (out_ready),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .overrun      (overrun)
   );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance share stimulus.
module tb_sipo_deserializer;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       serial_in;
   logic       serial_valid;
   logic       out_ready;
   logic [3:0] parallel_out, lsb_parallel_out;
   logic       out_valid, lsb_out_valid;
   logic       overrun, lsb_overrun;
`ifdef SIPO_PARITY_EN
   logic       parity_err, lsb_parity_err;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic vb;

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
`ifdef SIPO_PARITY_EN
      .parity_err   (parity_err),
`endif
      .overrun      (overrun)
   );

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .parallel_out (lsb_parallel_out),
      .out_valid    (lsb_out_valid),
      .out_ready    (out_ready),
`ifdef SIPO_PARITY_EN
      .parity_err   (lsb_parity_err),
`endif
      .overrun      (lsb_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends w MSB of the literal first; with parity enabled an even-parity bit
   // (inverted when par_flip=1) follows. vb_o is out_valid just before the final edge.
   task automatic send_word(input logic [3:0] w, input bit gaps, input bit ready_last,
                            input bit par_flip, output logic vb_o);
      logic [4:0] bits;
      int lo;
      bits = {w, (^w) ^ par_flip};
`ifdef SIPO_PARITY_EN
      lo = 0;
`else
      lo = 1;
`endif
      vb_o = 1'b0;
      for (int i = 4; i >= lo; i--) begin
         if (i == lo) begin
            vb_o      = out_valid;
            out_ready = ready_last;
         end
         serial_in    = bits[i];
         serial_valid = 1'b1;
         step();
         serial_valid = 1'b0;
         out_ready    = 1'b0;
         if (gaps && i != lo) step();
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; out_ready = 1'b0;
      step();
      check("rst_pout", parallel_out, 4'b0000);
      check("rst_valid", out_valid, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      reset = 1'b1;

      send_word(4'b1011, 1'b0, 1'b0, 1'b0, vb);
      check("basic_early", vb, 1'b0);
      check("basic_pout", parallel_out, 4'b1011);
      check("basic_valid", out_valid, 1'b1);
      check("basic_ovr", overrun, 1'b0);
      check("basic_lsb_pout", lsb_parallel_out, 4'b1101);
      accept();
      check("basic_acc_valid", out_valid, 1'b0);

      send_word(4'b1011, 1'b1, 1'b0, 1'b0, vb);
      check("gap_early", vb, 1'b0);
      check("gap_pout", parallel_out, 4'b1011);
      check("gap_valid", out_valid, 1'b1);
      accept();

      send_word(4'b1011, 1'b0, 1'b0, 1'b0, vb);
      send_word(4'b0110, 1'b0, 1'b0, 1'b0, vb);
      check("ovr_pout", parallel_out, 4'b1011);
      check("ovr_flag", overrun, 1'b1);
      check("ovr_valid", out_valid, 1'b1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_ovr", overrun, 1'b0);
      check("clr_valid", out_valid, 1'b1);
      check("clr_pout", parallel_out, 4'b1011);
      accept();

      send_word(4'b1100, 1'b0, 1'b0, 1'b0, vb);
      check("sim_first", parallel_out, 4'b1100);
      send_word(4'b0011, 1'b0, 1'b1, 1'b0, vb);
      check("sim_pout", parallel_out, 4'b0011);
      check("sim_valid", out_valid, 1'b1);
      check("sim_ovr", overrun, 1'b0);
      accept();
      check("sim_acc_valid", out_valid, 1'b0);

      serial_valid = 1'b1; serial_in = 1'b1;
      step();
      step();
      serial_valid = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_pout", parallel_out, 4'b0000);
      send_word(4'b0101, 1'b0, 1'b0, 1'b0, vb);
      check("midrst_early", vb, 1'b0);
      check("midrst_word", parallel_out, 4'b0101);
      check("midrst_lsb_word", lsb_parallel_out, 4'b1010);
      accept();

      send_word(4'b1101, 1'b0, 1'b0, 1'b0, vb);
      check("lsb_word", lsb_parallel_out, 4'b1011);
      check("msb_word", parallel_out, 4'b1101);
      accept();

      serial_valid = 1'b1; serial_in = 1'b1;
      step();
      step();
      clear = 1'b1;
      step();
      clear = 1'b0; serial_valid = 1'b0;
      send_word(4'b0110, 1'b0, 1'b0, 1'b0, vb);
      check("midclr_early", vb, 1'b0);
      check("midclr_word", parallel_out, 4'b0110);
      accept();

`ifdef SIPO_PARITY_EN
      send_word(4'b1011, 1'b0, 1'b0, 1'b0, vb);
      check("par_ok_early", vb, 1'b0);
      check("par_ok_pout", parallel_out, 4'b1011);
      check("par_ok_err", parity_err, 1'b0);
      accept();
      send_word(4'b1011, 1'b0, 1'b0, 1'b1, vb);
      check("par_bad_early", vb, 1'b0);
      check("par_bad_valid", out_valid, 1'b1);
      check("par_bad_err", parity_err, 1'b1);
      accept();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
